// File: rtl/rv32i_types.sv
// Shared types for the rv32i pipeline: pipe-stage occupancy state and the
// payload carried between stages. Instantiating sites build a
// stage_payload_t and pass WIDTH = $bits(stage_payload_t) to
// pipe_stage_skid_reg.
package rv32i_types;

  // Occupancy of a two-entry pipe stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // Decoded control bits that travel alongside an instruction.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
  } control_word_t;

  // Everything a downstream stage needs about one instruction.
  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   ir;
    logic [31:0]   rs1_val;
    logic [31:0]   rs2_val;
    control_word_t ctrl;
  } stage_payload_t;

  localparam int unsigned STAGE_PAYLOAD_W = $bits(stage_payload_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipe-stage statistics. Counts one per
// cycle with inc high, sticks at all-ones, clears on synchronous rst.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: advance on inc unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Two-entry (main + skid) pipeline register with valid/ready handshakes.
// in_ready depends on state only, so there is no combinational path from
// out_ready back to in_ready, and full throughput is kept with out_ready high.
// flush drops all held entries without touching the payload registers.
// Optional macro PIPE_STAGE_STATS_EN adds saturating stall_cnt / flush_cnt.
module pipe_stage_skid_reg
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Reject illegal parameterisations at elaboration time.
  if ((WIDTH < 1) || (WIDTH > 1024)) begin : g_bad_width
    $error("pipe_stage_skid_reg: WIDTH must be in 1..1024");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_skid_reg: CNT_W must be at least 1");
  end

  stage_state_t     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  // Handshake outputs are decoded from the state register alone.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Next-state and payload steering; flush overrides every transfer.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned -- otherwise synthesis infers a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and payload registers; reset clears the payload too so out_data
  // reads zero straight out of reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic stall_inc;
  logic flush_inc;

  // A stall is a held entry the downstream stage declines; a counted flush
  // is one that actually discarded something.
  assign stall_inc = out_valid && !out_ready;
  assign flush_inc = flush && (state_q != EMPTY);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
`endif

endmodule
